// File: rtl/player_motion_engine.sv
// Purpose : moves a player sprite one pixel per STEP_DIV cycles (diagonally when
//           both axes differ) from its current position to a latched target.
// Latency : first step STEP_DIV edges after the start edge; done d*STEP_DIV+1 edges
//           after it, where d = max(|dx|,|dy|).
// Backpressure: none; a start event arriving while a move is running is dropped.
//
// Ports
//   clock   in   1  rising-edge clock
//   reset   in   1  synchronous active-high reset
//   start   in  32  command word, bit 0 is the start request (rising edge triggers)
//   player  in  32  target: [9:0] x, [25:16] y
//   eoc     out 32  status: [0] done, [1] busy, [11:2] pos_x, [21:12] pos_y, rest 0
//   pos_x   out 10  current x position (registered)
//   pos_y   out 10  current y position (registered)

module player_motion_engine #(
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned X_MAX    = 639,
   parameter int unsigned Y_MAX    = 479,
   parameter int unsigned X_HOME   = 0,
   parameter int unsigned Y_HOME   = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] start,
   input  logic [31:0] player,
   output logic [31:0] eoc,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y
);

   localparam logic [9:0] X_MAX_C  = 10'(X_MAX);
   localparam logic [9:0] Y_MAX_C  = 10'(Y_MAX);
   localparam logic [9:0] X_HOME_C = 10'(X_HOME);
   localparam logic [9:0] Y_HOME_C = 10'(Y_HOME);
   // Divider value on which a step is taken; STEP_DIV=1 steps on every edge.
   localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        start_q, start_d;
   logic [7:0]  div_q, div_d;
   logic [9:0]  tgt_x_q, tgt_x_d;
   logic [9:0]  tgt_y_q, tgt_y_d;
   logic [9:0]  pos_x_q, pos_x_d;
   logic [9:0]  pos_y_q, pos_y_d;
   // Only the 22 meaningful status bits are stored; the top 10 are constant zero.
   logic [21:0] eoc_q, eoc_d;

   logic        start_evt;
   logic [9:0]  req_x, req_y;
   logic        at_tgt;
   logic        step_now;
   logic [9:0]  step_x, step_y;

   // Command bits and target bits outside the defined fields are don't-care.
   logic unused_in_bits;
   assign unused_in_bits = ^{start[31:1], player[31:26], player[15:10]};

   assign start_evt = start[0] & ~start_q;

   // Clamp the requested target into the playfield so motion can never leave it.
   assign req_x = (player[9:0]   > X_MAX_C) ? X_MAX_C : player[9:0];
   assign req_y = (player[25:16] > Y_MAX_C) ? Y_MAX_C : player[25:16];

   assign at_tgt   = (pos_x_q == tgt_x_q) && (pos_y_q == tgt_y_q);
   assign step_now = (div_q == DIV_LAST);

   // One pixel toward the target on each axis; an axis already on target holds.
   // Target is clamped and position starts in range, so +/-1 never wraps.
   always_comb begin
      step_x = pos_x_q;
      step_y = pos_y_q;
      if (pos_x_q < tgt_x_q) begin
         step_x = pos_x_q + 10'd1;
      end else if (pos_x_q > tgt_x_q) begin
         step_x = pos_x_q - 10'd1;
      end
      if (pos_y_q < tgt_y_q) begin
         step_y = pos_y_q + 10'd1;
      end else if (pos_y_q > tgt_y_q) begin
         step_y = pos_y_q - 10'd1;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      start_d = start[0];
      div_d   = div_q;
      tgt_x_d = tgt_x_q;
      tgt_y_d = tgt_y_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_evt) begin
               tgt_x_d = req_x;
               tgt_y_d = req_y;
               div_d   = 8'd0;
               state_d = ST_MOVE;
            end
         end
         ST_MOVE: begin
            // Start events are deliberately not looked at here.
            if (at_tgt) begin
               state_d = ST_DONE;
            end else if (step_now) begin
               div_d   = 8'd0;
               pos_x_d = step_x;
               pos_y_d = step_y;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status is built from next-state values so it lines up with pos_x/pos_y
      // and the state on the same edge while still coming straight from a flop.
      eoc_d = {pos_y_d, pos_x_d, (state_d == ST_MOVE), (state_d == ST_DONE)};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         // Loaded high so a start bit held through reset is not seen as a rise.
         start_q <= 1'b1;
         div_q   <= 8'd0;
         tgt_x_q <= X_HOME_C;
         tgt_y_q <= Y_HOME_C;
         pos_x_q <= X_HOME_C;
         pos_y_q <= Y_HOME_C;
         eoc_q   <= {Y_HOME_C, X_HOME_C, 2'b00};
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         div_q   <= div_d;
         tgt_x_q <= tgt_x_d;
         tgt_y_q <= tgt_y_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         eoc_q   <= eoc_d;
      end
   end

   assign eoc   = {10'b0, eoc_q};
   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;

endmodule
